alu_rs: RTL

//  Reservation station and issue scheduler for the integer ALU. Buffers dispatched
//  ALU/branch/JAL/AUIPC ops and snoops two CDBs (ALU result, LSB result) to resolve

---
 rtl/alu_rs_pkg.sv | 35 +++
 rtl/alu_rs_prio_enc.sv | 25 ++
 rtl/alu_rs.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: RV32I opcodes, sizing
// constants, the entry field layout and a CDB tag-match helper.
package alu_rs_pkg;

    localparam int RS_SIZE = 8;
    localparam int ROB_W   = 4;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       precise;
        logic             more_precise;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [ROB_W-1:0] rob;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic             qj_busy;
        logic             qk_busy;
        logic [ROB_W-1:0] qj;
        logic [ROB_W-1:0] qk;
    } rs_entry_t;

    function automatic logic cdb_hit(input logic             cdb_valid,
                                     input logic [ROB_W-1:0] cdb_rob,
                                     input logic [ROB_W-1:0] tag);
        return cdb_valid && (cdb_rob == tag);
    endfunction

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request bit
// and a flag saying whether any bit was set.
module rs_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    // NOTE: every output gets a default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scanning downward lets the lowest set bit be the last writer.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = i[$clog2(N)-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station: buffers dispatched ops, snoops the ALU and
// LSB CDBs for operand tags, and issues the lowest-index ready entry per cycle.
module alu_rs #(
    parameter int RS_SIZE = alu_rs_pkg::RS_SIZE,
    parameter int ROB_W   = alu_rs_pkg::ROB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             disp_valid,
    input  logic [6:0]       disp_opcode,
    input  logic [2:0]       disp_precise,
    input  logic             disp_more_precise,
    input  logic [31:0]      disp_pc,
    input  logic [31:0]      disp_imm,
    input  logic [ROB_W-1:0] disp_rob,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic             disp_qj_busy,
    input  logic             disp_qk_busy,
    input  logic [ROB_W-1:0] disp_qj,
    input  logic [ROB_W-1:0] disp_qk,
    input  logic             alu_cdb_valid,
    input  logic [ROB_W-1:0] alu_cdb_rob,
    input  logic [31:0]      alu_cdb_val,
    input  logic             lsb_cdb_valid,
    input  logic [ROB_W-1:0] lsb_cdb_rob,
    input  logic [31:0]      lsb_cdb_val,
    output logic             rs_full,
    output logic             iss_config,
    output logic [31:0]      iss_a,
    output logic [31:0]      iss_b,
    output logic [31:0]      iss_pc,
    output logic [31:0]      iss_imm,
    output logic [6:0]       iss_opcode,
    output logic [2:0]       iss_precise,
    output logic             iss_more_precise,
    output logic [ROB_W-1:0] iss_rob
);

    import alu_rs_pkg::*;

    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t          ent [RS_SIZE];
    logic [RS_SIZE-1:0] valid;
    logic [RS_SIZE-1:0] ready;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               free_found;
    logic               sel_found;
    logic               no_rs1;
    logic               no_rs2;
    logic               disp_fire;
    rs_entry_t          disp_entry;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = valid[i] && !ent[i].qj_busy && !ent[i].qk_busy;
        end
    end

    rs_prio_enc #(.N(RS_SIZE)) u_free_enc (.req(~valid), .idx(free_idx), .found(free_found));
    rs_prio_enc #(.N(RS_SIZE)) u_sel_enc  (.req(ready),  .idx(sel_idx),  .found(sel_found));

    assign rs_full   = !free_found;
    assign disp_fire = disp_valid && free_found;

    // Incoming entry, with operand-usage masking and same-cycle CDB capture.
    always_comb begin
        no_rs2 = (disp_opcode == OP_IMM) || (disp_opcode == AUIPC) || (disp_opcode == JAL);
        no_rs1 = (disp_opcode == AUIPC) || (disp_opcode == JAL);

        disp_entry              = '0;
        disp_entry.opcode       = disp_opcode;
        disp_entry.precise      = disp_precise;
        disp_entry.more_precise = disp_more_precise;
        disp_entry.pc           = disp_pc;
        disp_entry.imm          = disp_imm;
        disp_entry.rob          = disp_rob;
        disp_entry.vj           = disp_vj;
        disp_entry.vk           = disp_vk;
        disp_entry.qj           = disp_qj;
        disp_entry.qk           = disp_qk;
        disp_entry.qj_busy      = disp_qj_busy && !no_rs1;
        disp_entry.qk_busy      = disp_qk_busy && !no_rs2;

        if (disp_entry.qj_busy && cdb_hit(alu_cdb_valid, alu_cdb_rob, disp_qj)) begin
            disp_entry.vj      = alu_cdb_val;
            disp_entry.qj_busy = 1'b0;
        end else if (disp_entry.qj_busy && cdb_hit(lsb_cdb_valid, lsb_cdb_rob, disp_qj)) begin
            disp_entry.vj      = lsb_cdb_val;
            disp_entry.qj_busy = 1'b0;
        end

        if (disp_entry.qk_busy && cdb_hit(alu_cdb_valid, alu_cdb_rob, disp_qk)) begin
            disp_entry.vk      = alu_cdb_val;
            disp_entry.qk_busy = 1'b0;
        end else if (disp_entry.qk_busy && cdb_hit(lsb_cdb_valid, lsb_cdb_rob, disp_qk)) begin
            disp_entry.vk      = lsb_cdb_val;
            disp_entry.qk_busy = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid            <= '0;
            iss_config       <= 1'b0;
            iss_a            <= '0;
            iss_b            <= '0;
            iss_pc           <= '0;
            iss_imm          <= '0;
            iss_opcode       <= '0;
            iss_precise      <= '0;
            iss_more_precise <= 1'b0;
            iss_rob          <= '0;
        end else if (rdy) begin
            if (rollback) begin
                valid            <= '0;
                iss_config       <= 1'b0;
                iss_a            <= '0;
                iss_b            <= '0;
                iss_pc           <= '0;
                iss_imm          <= '0;
                iss_opcode       <= '0;
                iss_precise      <= '0;
                iss_more_precise <= 1'b0;
                iss_rob          <= '0;
            end else begin
                iss_config <= sel_found;
                if (sel_found) begin
                    iss_a            <= ent[sel_idx].vj;
                    iss_b            <= ent[sel_idx].vk;
                    iss_pc           <= ent[sel_idx].pc;
                    iss_imm          <= ent[sel_idx].imm;
                    iss_opcode       <= ent[sel_idx].opcode;
                    iss_precise      <= ent[sel_idx].precise;
                    iss_more_precise <= ent[sel_idx].more_precise;
                    iss_rob          <= ent[sel_idx].rob;
                    valid[sel_idx]   <= 1'b0;
                end
                // The free slot comes from stored valid bits, so it never
                // aliases the slot being issued this cycle.
                if (disp_fire) begin
                    valid[free_idx] <= 1'b1;
                end
            end
        end
    end

    // NOTE: entry payload has no reset; the valid bits alone decide whether
    // a slot's contents mean anything.
    always_ff @(posedge clk) begin
        if (rdy && !rollback) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid[i] && ent[i].qj_busy) begin
                    if (cdb_hit(alu_cdb_valid, alu_cdb_rob, ent[i].qj)) begin
                        ent[i].vj      <= alu_cdb_val;
                        ent[i].qj_busy <= 1'b0;
                    end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_rob, ent[i].qj)) begin
                        ent[i].vj      <= lsb_cdb_val;
                        ent[i].qj_busy <= 1'b0;
                    end
                end
                if (valid[i] && ent[i].qk_busy) begin
                    if (cdb_hit(alu_cdb_valid, alu_cdb_rob, ent[i].qk)) begin
                        ent[i].vk      <= alu_cdb_val;
                        ent[i].qk_busy <= 1'b0;
                    end else if (cdb_hit(lsb_cdb_valid, lsb_cdb_rob, ent[i].qk)) begin
                        ent[i].vk      <= lsb_cdb_val;
                        ent[i].qk_busy <= 1'b0;
                    end
                end
            end
            if (disp_fire) begin
                ent[free_idx] <= disp_entry;
            end
        end
    end

endmodule
